// File: rtl/imem_server_pkg.sv
// imem_server_pkg: shared fetch-path widths, NOP encoding, response record and error rule
package imem_server_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            err;
  } resp_t;
  function automatic logic fetch_err(input logic [XLEN-1:0] addr, input int unsigned words);
    return addr[1:0] != 2'b00 || {2'b00, addr[XLEN-1:2]} >= words;
  endfunction
endpackage

// File: rtl/imem_server_resp_fifo.sv
// resp_fifo: show-ahead synchronous FIFO with a synchronous clear
module resp_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_wr, do_rd;
  assign valid   = cnt != '0;
  assign rd_data = mem[rp];
  assign do_rd   = rd_en & valid;
  assign do_wr   = wr_en & (cnt < (AW+1)'(DEPTH) | do_rd);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (clear) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_wr) wp <= wp == AW'(DEPTH-1) ? '0 : wp + 1'b1;
      if (do_rd) rp <= rp == AW'(DEPTH-1) ? '0 : rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  always_ff @(posedge clk)
    if (do_wr && !clear) mem[wp] <= wr_data;
endmodule

// File: rtl/imem_server.sv
// imem_server: fixed-latency instruction ROM responder with credit flow control and flush
module imem_server import imem_server_pkg::*; #(
  parameter int    MEM_WORDS = 1024,
  parameter int    LATENCY   = 2,
  parameter int    OUTQ      = 4,
  parameter string INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_pc,
  output logic [ILEN-1:0] resp_instr,
  output logic            resp_err,
  output logic            busy
);
  localparam int AW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
  localparam int CW = $clog2(OUTQ + 1);
  logic [ILEN-1:0] rom [MEM_WORDS];
  logic accept, pop, f_err, wr_en, head_valid;
  logic [CW-1:0] count;
  resp_t fetch_d, wr_data, head;
  assign req_ready  = rst_n & !flush & (count < CW'(OUTQ));
  assign accept     = req_valid & req_ready;
  assign resp_valid = head_valid;
  assign pop        = resp_valid & resp_ready;
  assign busy       = count != '0;
  assign f_err      = fetch_err(req_addr, MEM_WORDS);
  assign fetch_d    = '{pc: req_addr, instr: f_err ? INSTR_NOP : rom[req_addr[AW+1:2]], err: f_err};
  assign resp_pc    = resp_valid ? head.pc : '0;
  assign resp_instr = resp_valid ? head.instr : '0;
  assign resp_err   = resp_valid & head.err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= flush ? '0 : count + CW'(accept) - CW'(pop);
  if (LATENCY == 1) begin : g_direct
    assign wr_en   = accept;
    assign wr_data = fetch_d;
  end else begin : g_pipe
    logic [LATENCY-2:0] pv;
    logic [LATENCY-1:0] chain;
    resp_t pd [LATENCY-1];
    assign chain   = {pv, accept};
    assign wr_en   = pv[LATENCY-2];
    assign wr_data = pd[LATENCY-2];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pv <= '0;
      else pv <= flush ? '0 : chain[LATENCY-2:0];
    always_ff @(posedge clk) begin
      pd[0] <= fetch_d;
      for (int i = 1; i < LATENCY - 1; i++) pd[i] <= pd[i-1];
    end
  end
  resp_fifo #(.WIDTH($bits(resp_t)), .DEPTH(OUTQ)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (flush),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .rd_en  (resp_ready),
    .rd_data(head),
    .valid  (head_valid)
  );
endmodule

// File: tb/tb_imem_server.sv
// tb_imem_server: table vectors, directed corner sequences and a randomized queue-model check
module tb_imem_server;
  localparam int MW = 1024;
  localparam int L  = 2;
  localparam int Q  = 4;
  logic clk = 0, rst_n = 0, req_valid = 0, flush = 0, resp_ready = 0;
  logic [31:0] req_addr = 0;
  logic req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_pc, resp_instr;
  always #5 clk = ~clk;
  imem_server #(.MEM_WORDS(MW), .LATENCY(L), .OUTQ(Q)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pc(resp_pc),
    .resp_instr(resp_instr), .resp_err(resp_err), .busy(busy)
  );
  typedef struct {logic [31:0] pc; logic [31:0] instr; logic err; int vis;} ent_t;
  typedef struct {logic [31:0] addr; logic [31:0] instr; logic err;} vec_t;
  int tests = 0, fails = 0, cyc = 0, accepts = 0;
  logic [31:0] rom_m [MW];
  ent_t q[$];
  vec_t vecs[8];
  function automatic logic m_err(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= MW);
  endfunction
  function automatic logic [31:0] m_instr(input logic [31:0] a);
    return m_err(a) ? 32'h0000_0013 : rom_m[10'(a / 4)];
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %h expected %h", n, cyc, act, exp);
    end
  endtask
  task automatic cycle(input logic rv, input logic [31:0] a, input logic fl, input logic rr);
    logic e_rdy, e_rv;
    req_valid = rv; req_addr = a; flush = fl; resp_ready = rr;
    #2;
    e_rdy = !fl && q.size() < Q;
    e_rv  = q.size() > 0 && q[0].vis <= cyc;
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("resp_valid", 32'(resp_valid), 32'(e_rv));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    chk("resp_pc", resp_pc, e_rv ? q[0].pc : 32'h0);
    chk("resp_instr", resp_instr, e_rv ? q[0].instr : 32'h0);
    chk("resp_err", 32'(resp_err), e_rv ? 32'(q[0].err) : 32'h0);
    if (rv && req_ready) accepts++;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (e_rv && rr) void'(q.pop_front());
      if (rv && e_rdy) q.push_back('{a, m_instr(a), m_err(a), cyc + L});
    end
    cyc++;
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_resp_pc", resp_pc, 0);
    chk("rst_resp_instr", resp_instr, 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    q.delete();
    req_valid = 0; flush = 0; resp_ready = 0;
    repeat (2) begin @(posedge clk); cyc++; end
    #1;
    rst_n = 1;
  endtask
  initial begin
    for (int i = 0; i < MW; i++) rom_m[i] = $urandom;
    rom_m[0] = 32'h0050_0093;
    rom_m[1] = 32'h00A0_0113;
    rom_m[2] = 32'h0020_81B3;
    rom_m[3] = 32'h4011_0233;
    rom_m[MW-1] = 32'h0000_006F;
    for (int i = 0; i < MW; i++) dut.rom[i] = rom_m[i];
    vecs[0] = '{32'h0000_0000, 32'h0050_0093, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'h00A0_0113, 1'b0};
    vecs[2] = '{32'h0000_0002, 32'h0000_0013, 1'b1};
    vecs[3] = '{32'h0000_1000, 32'h0000_0013, 1'b1};
    vecs[4] = '{32'h0000_0FFC, 32'h0000_006F, 1'b0};
    vecs[5] = '{32'h0000_0FFF, 32'h0000_0013, 1'b1};
    vecs[6] = '{32'hFFFF_FFFC, 32'h0000_0013, 1'b1};
    vecs[7] = '{32'h0000_000C, 32'h4011_0233, 1'b0};
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1, vecs[i].addr, 0, 0);
      cycle(0, 0, 0, 0);
      chk("vec_valid", 32'(resp_valid), 1);
      chk("vec_pc", resp_pc, vecs[i].addr);
      chk("vec_instr", resp_instr, vecs[i].instr);
      chk("vec_err", 32'(resp_err), 32'(vecs[i].err));
      cycle(0, 0, 0, 1);
    end
    for (int k = 0; k < 4; k++) cycle(1, 32'(4 * k), 0, 1);
    repeat (4) cycle(0, 0, 0, 1);
    accepts = 0;
    for (int k = 0; k < 6; k++) cycle(1, 32'h10 + 32'(4 * k), 0, 0);
    chk("credit_accepts", 32'(accepts), 4);
    repeat (2) cycle(0, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle(1, 32'(4 * k), 0, 0);
    accepts = 0;
    cycle(1, 32'h20, 1, 0);
    chk("flush_no_accept", 32'(accepts), 0);
    cycle(0, 0, 0, 1);
    chk("flush_busy", 32'(busy), 0);
    cycle(1, 32'h8, 0, 1);
    repeat (3) cycle(0, 0, 0, 1);
    cycle(1, 32'h0, 0, 0);
    cycle(1, 32'h4, 0, 0);
    cycle(0, 0, 0, 0);
    chk("pre_reset_valid", 32'(resp_valid), 1);
    do_reset();
    repeat (4) cycle(0, 0, 0, 1);
    for (int k = 0; k < 600; k++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = r < 7 ? 32'(4 * $urandom_range(0, MW - 1)) :
          r == 7 ? 32'($urandom) :
          r == 8 ? 32'(4 * $urandom_range(0, MW - 1) + $urandom_range(1, 3)) :
          32'(4 * MW - 4 * $urandom_range(0, 1));
      if (k == 300) do_reset();
      cycle($urandom_range(0, 99) < 60, a, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 70);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
